// File: rtl/bch_pkg.sv
// Shared constants and types for the serial BCH(63,51,t=2) encoder.
package bch_pkg;

    localparam int BCH_N = 63;
    localparam int BCH_K = 51;
    localparam int BCH_P = 12;

    localparam logic [12:0] BCH_GEN_POLY   = 13'h1539;
    localparam logic [11:0] BCH_X12_MOD_G  = 12'h539;
    localparam logic [6:0]  BCH_FIELD_POLY = 7'h43;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PARITY,
        ST_DATA
    } t_bch_enc_state;

    // Multiply a residue by x and reduce modulo g(x).
    function automatic logic [BCH_P-1:0] mul_x_mod_g(input logic [BCH_P-1:0] v);
        return {v[BCH_P-2:0], 1'b0} ^ (v[BCH_P-1] ? BCH_GEN_POLY[BCH_P-1:0] : '0);
    endfunction

endpackage

// File: rtl/bch_encoder_if.sv
// Stream handshake bundle for bch_encoder; BCH_ENC_ERR_INJECT_EN adds error-injection controls.
interface bch_encoder_if;

    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_data;
    logic       out_ready;
    logic       out_last;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic       err_inj;
    logic [5:0] err_pos0;
    logic [5:0] err_pos1;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
`ifdef BCH_ENC_ERR_INJECT_EN
        , output err_inj, err_pos0, err_pos1
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
`ifdef BCH_ENC_ERR_INJECT_EN
        , input err_inj, err_pos0, err_pos1
`endif
    );

endinterface

// File: rtl/bch_rem_accum.sv
// Parity accumulator: R collects x^(12+k) mod g for every set message bit; T walks those residues.
module bch_rem_accum
    import bch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             bit_in,
    output logic [BCH_P-1:0] rem,
    output logic             rem_lsb_next
);

    logic [BCH_P-1:0] tap;

    // Bit 0 of R including the bit being accepted now, so c_0 can be presented without a bubble.
    assign rem_lsb_next = rem[0] ^ (step & bit_in & tap[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            tap <= BCH_X12_MOD_G;
        end else begin
            if (clear)
                rem <= '0;
            else if (step && bit_in)
                rem <= rem ^ tap;

            if (load)
                tap <= BCH_X12_MOD_G;
            else if (step)
                tap <= mul_x_mod_g(tap);
        end
    end

endmodule

// File: rtl/bch_encoder.sv
// Systematic serial BCH(63,51) encoder, x^0 first: 12 parity bits, then the 51 message bits.
// Optional macro BCH_ENC_ERR_INJECT_EN enables inversion of up to two output positions per frame.
module bch_encoder
    import bch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    bch_encoder_if.slave bus
);

    t_bch_enc_state   state;
    logic [5:0]       k;
    logic [5:0]       j;
    logic [BCH_K-1:0] msg_buf;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_data_r;
    logic             out_last_r;
    logic [BCH_P-1:0] rem;
    logic             rem_lsb_next;
    logic             take;
    logic             give;
    logic             frame_end;
    logic [3:0]       par_idx;
    logic [5:0]       data_idx;
    logic             flip_first;
    logic             flip_next;

    assign take      = in_ready_r && bus.in_valid;
    assign give      = out_valid_r && bus.out_ready;
    assign frame_end = give && (state == ST_DATA) && (j == 6'd62);
    assign par_idx   = j[3:0] + 4'd1;
    assign data_idx  = j - 6'd11;

    bch_rem_accum u_accum (
        .clk          (clk),
        .rst          (rst),
        .clear        (frame_end),
        .load         (frame_end),
        .step         (take),
        .bit_in       (bus.in_data),
        .rem          (rem),
        .rem_lsb_next (rem_lsb_next)
    );

`ifdef BCH_ENC_ERR_INJECT_EN
    logic       inj_q;
    logic [5:0] pos0_q;
    logic [5:0] pos1_q;

    function automatic logic flip(input logic en, input logic [5:0] p0,
                                  input logic [5:0] p1, input logic [5:0] idx);
        return en && ((idx == p0) || (idx == p1));
    endfunction

    // Controls are captured together with c_0 so that position 0 can be hit too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_q  <= 1'b0;
            pos0_q <= 6'd63;
            pos1_q <= 6'd63;
        end else if (take && (k == 6'd50)) begin
            inj_q  <= bus.err_inj;
            pos0_q <= bus.err_pos0;
            pos1_q <= bus.err_pos1;
        end
    end

    assign flip_first = flip(bus.err_inj, bus.err_pos0, bus.err_pos1, 6'd0);
    assign flip_next  = flip(inj_q, pos0_q, pos1_q, j + 6'd1);
`else
    assign flip_first = 1'b0;
    assign flip_next  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (take)
            msg_buf[k] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_LOAD;
            k           <= '0;
            j           <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (take) begin
                        if (k == 6'd50) begin
                            state       <= ST_PARITY;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_data_r  <= rem_lsb_next ^ flip_first;
                        end else begin
                            k <= k + 6'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (give) begin
                        j <= j + 6'd1;
                        if (j == 6'd11) begin
                            state      <= ST_DATA;
                            out_data_r <= msg_buf[data_idx] ^ flip_next;
                        end else begin
                            out_data_r <= rem[par_idx] ^ flip_next;
                        end
                    end
                end
                ST_DATA: begin
                    if (give) begin
                        if (j == 6'd62) begin
                            state       <= ST_LOAD;
                            k           <= '0;
                            j           <= '0;
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                            out_data_r  <= 1'b0;
                            out_last_r  <= 1'b0;
                        end else begin
                            j          <= j + 6'd1;
                            out_data_r <= msg_buf[data_idx] ^ flip_next;
                            out_last_r <= (j == 6'd61);
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder; covers BCH_ENC_ERR_INJECT_EN when that macro is defined.
module tb_bch_encoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bch_encoder_if bus ();

    bch_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int gf_exp[63];

    typedef struct {
        logic [50:0] msg;
        logic [62:0] cw;
    } vec_t;

    vec_t        tbl[6];
    logic [62:0] got;
    logic [62:0] exp_cw;
    logic [62:0] shifted;
    logic [50:0] m;
    logic [63:0] r;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Remainder of a polynomial (bit i = coefficient of x^i) by long division with g(x).
    function automatic logic [11:0] poly_mod_g(input logic [62:0] c);
        logic [62:0] d = c;
        logic [62:0] g = 63'h1539;
        for (int i = 62; i >= 12; i--)
            if (d[i]) d = d ^ (g << (i - 12));
        return d[11:0];
    endfunction

    function automatic logic [62:0] golden(input logic [50:0] msg);
        logic [62:0] d = {msg, 12'b0};
        return d | {51'b0, poly_mod_g(d)};
    endfunction

    function automatic int syndrome(input logic [62:0] c, input int pw);
        int s = 0;
        for (int i = 0; i < 63; i++)
            if (c[i]) s = s ^ gf_exp[(pw * i) % 63];
        return s;
    endfunction

    task automatic send_msg(input logic [50:0] msg, input int gap_pct);
        int k = 0;
        int guard = 0;
        bus.out_ready = 1'b0;
        while (k < 51 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 1'($urandom_range(1));
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = msg[k];
            end
            if (bus.in_valid && bus.in_ready) begin
                k++;
                if (k == 51) check(bus.out_valid == 1'b0, "pre_latency_valid", bus.out_valid, 0);
            end
        end
        if (k < 51) check(1'b0, "send_timeout", k, 51);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check(bus.out_valid && !bus.in_ready, "latency_valid", {bus.out_valid, bus.in_ready}, 2'b10);
    endtask

    task automatic recv_frame(input int rnd_pct, input int stall_a, input int stall_b,
                              input int abort_at, output logic [62:0] cw);
        int idx = 0;
        int guard = 0;
        int stall_cnt = 0;
        bit sa_done = 0, sb_done = 0, hold = 0, pd = 0, pl = 0, done = 0, ok, rdy;
        cw = '0;
        while (!done && guard < 20000) begin
            @(negedge clk);
            guard++;
            ok = bus.out_valid && !bus.in_ready &&
                 (!hold || (bus.out_data == pd && bus.out_last == pl));
            check(ok, "out_hold", {bus.out_valid, bus.in_ready, bus.out_data, bus.out_last},
                  {1'b1, 1'b0, pd, pl});
            if (idx == abort_at) begin
                bus.out_ready = 1'b0;
                rst = 1'b1;
                #1;
                check(bus.out_valid == 1'b0, "rst_async_drop", bus.out_valid, 0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check(bus.out_valid == 1'b0 && bus.in_ready, "rst_no_resume",
                      {bus.out_valid, bus.in_ready}, 2'b01);
                done = 1;
            end else begin
                if (stall_cnt == 0 && idx == stall_a && !sa_done) begin stall_cnt = 20; sa_done = 1; end
                if (stall_cnt == 0 && idx == stall_b && !sb_done) begin stall_cnt = 20; sb_done = 1; end
                if (stall_cnt > 0) begin
                    rdy = 0;
                    stall_cnt--;
                end else begin
                    rdy = ($urandom_range(99) >= rnd_pct);
                end
                bus.out_ready = rdy;
                if (bus.out_valid && rdy) begin
                    cw[idx] = bus.out_data;
                    check(bus.out_last == (idx == 62), "out_last", bus.out_last, idx == 62);
                    idx++;
                    hold = 0;
                    if (idx == 63) done = 1;
                end else begin
                    hold = bus.out_valid;
                    pd   = bus.out_data;
                    pl   = bus.out_last;
                end
            end
        end
        if (!done) begin
            check(1'b0, "recv_timeout", idx, 63);
        end else if (abort_at < 0) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            check(!bus.out_valid && bus.in_ready, "frame_end", {bus.out_valid, bus.in_ready}, 2'b01);
        end
    endtask

    initial begin
        int a = 1;
        for (int i = 0; i < 63; i++) begin
            gf_exp[i] = a;
            a = a << 1;
            if ((a & 64) != 0) a = a ^ 'h43;
        end

        tbl[0].msg = 51'd0; tbl[0].cw = 63'd0;
        tbl[1].msg = 51'd1; tbl[1].cw = 63'h1539;
        tbl[2].msg = 51'd2; tbl[2].cw = 63'h2A72;
        tbl[3].msg = 51'd3; tbl[3].cw = 63'h3F4B;
        shifted = 63'h1539 << 7;
        tbl[4].cw = shifted; tbl[4].msg = shifted[62:12];
        shifted = 63'h1539 << 50;
        tbl[5].cw = shifted; tbl[5].msg = shifted[62:12];

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef BCH_ENC_ERR_INJECT_EN
        bus.err_inj  = 1'b0;
        bus.err_pos0 = 6'd63;
        bus.err_pos1 = 6'd63;
`endif
        repeat (3) @(negedge clk);
        check(bus.out_valid == 1'b0, "reset_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last} == 4'b1000,
              "reset_state", {bus.in_ready, bus.out_valid, bus.out_data, bus.out_last}, 4'b1000);

        for (int i = 0; i < 6; i++) begin
            send_msg(tbl[i].msg, 0);
            recv_frame(0, -1, -1, -1, got);
            check(got == tbl[i].cw, "table_codeword", got, tbl[i].cw);
        end

        // Backpressure held for 20 cycles at two points in the frame.
        r = {$urandom(), $urandom()};
        m = r[50:0];
        send_msg(m, 20);
        recv_frame(0, 5, 40, -1, got);
        check(got == golden(m), "stall_codeword", got, golden(m));

        // Reset in the middle of the message section, then a clean frame.
        r = {$urandom(), $urandom()};
        m = r[50:0];
        send_msg(m, 0);
        recv_frame(0, -1, -1, 30, got);
        r = {$urandom(), $urandom()};
        m = r[50:0];
        send_msg(m, 10);
        recv_frame(10, -1, -1, -1, got);
        check(got == golden(m), "after_reset_codeword", got, golden(m));

`ifdef BCH_ENC_ERR_INJECT_EN
        r = {$urandom(), $urandom()};
        m = r[50:0];
        bus.err_inj = 1'b1; bus.err_pos0 = 6'd7; bus.err_pos1 = 6'd50;
        send_msg(m, 0);
        recv_frame(0, -1, -1, -1, got);
        check((got ^ golden(m)) == ((63'd1 << 7) | (63'd1 << 50)), "inject_two", got ^ golden(m),
              (63'd1 << 7) | (63'd1 << 50));
        bus.err_pos0 = 6'd20; bus.err_pos1 = 6'd20;
        send_msg(m, 0);
        recv_frame(0, -1, -1, -1, got);
        check((got ^ golden(m)) == (63'd1 << 20), "inject_same", got ^ golden(m), 63'd1 << 20);
        bus.err_pos0 = 6'd63; bus.err_pos1 = 6'd0;
        send_msg(m, 0);
        recv_frame(0, -1, -1, -1, got);
        check((got ^ golden(m)) == 63'd1, "inject_pos63", got ^ golden(m), 63'd1);
        bus.err_inj = 1'b0; bus.err_pos0 = 6'd7; bus.err_pos1 = 6'd50;
        send_msg(m, 0);
        recv_frame(0, -1, -1, -1, got);
        check(got == golden(m), "inject_off", got, golden(m));
`endif

        for (int f = 0; f < 200; f++) begin
            r = {$urandom(), $urandom()};
            m = r[50:0];
            send_msg(m, 30);
            recv_frame(30, -1, -1, -1, got);
            exp_cw = golden(m);
            check(got == exp_cw, "rand_codeword", got, exp_cw);
            check(poly_mod_g(got) == 12'd0, "rand_mod_g", poly_mod_g(got), 0);
            check(syndrome(got, 1) == 0, "rand_s1", syndrome(got, 1), 0);
            check(syndrome(got, 3) == 0, "rand_s3", syndrome(got, 3), 0);
            check(got[62:12] == m, "rand_systematic", got[62:12], m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
